// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage issue, WB completion and stall/status signals of the hazard scoreboard
//   master: pipeline side, drives ID/WB inputs, observes Stall/ID_EX_Bubble/Pending/Outstanding/Err/Hang
//   slave : scoreboard side
interface hazard_scoreboard_if;
  logic        ID_valid;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_rs1_used;
  logic        ID_rs2_used;
  logic [4:0]  ID_rd;
  logic        ID_RegWrite;
  logic        ID_long;
  logic        Flush;
  logic        WB_long_done;
  logic [4:0]  WB_rd;
  logic        Stall;
  logic        ID_EX_Bubble;
  logic [31:0] Pending;
  logic [3:0]  Outstanding;
  logic        Err;
  logic        Hang;
  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd, ID_RegWrite, ID_long,
           Flush, WB_long_done, WB_rd,
    input  Stall, ID_EX_Bubble, Pending, Outstanding, Err, Hang
  );
  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_rd, ID_RegWrite, ID_long,
           Flush, WB_long_done, WB_rd,
    output Stall, ID_EX_Bubble, Pending, Outstanding, Err, Hang
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage register scoreboard and stall controller for long-latency ops
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   sb (slave) : ID instruction fields, Flush, WB completion in; Stall/ID_EX_Bubble,
//                Pending bitmap, Outstanding count, sticky Err/Hang out
module hazard_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave sb
);
  logic [31:0] pending, clr, pend_eff, set;
  logic [3:0]  outstanding, cnt_eff;
  logic [7:0]  stall_cnt;
  logic        err, hang, hazard, stall, issue, inc, dec;
  // A completing writeback is bypassed into this cycle's hazard check; bit 0 is
  // never set, so x0 sources and destinations can never match.
  always_comb begin
    clr      = (sb.WB_long_done && sb.WB_rd != 5'd0) ? 32'd1 << sb.WB_rd : 32'd0;
    pend_eff = pending & ~clr;
    dec      = sb.WB_long_done && outstanding != 4'd0;
    cnt_eff  = outstanding - {3'd0, dec};
    hazard   = sb.ID_valid && ((sb.ID_rs1_used && pend_eff[sb.ID_rs1]) ||
                               (sb.ID_rs2_used && pend_eff[sb.ID_rs2]) ||
                               (sb.ID_RegWrite && pend_eff[sb.ID_rd]) ||
                               (sb.ID_long && cnt_eff == 4'(MAX_OUT)));
    stall    = hazard && !sb.Flush;
    issue    = sb.ID_valid && !stall && !sb.Flush;
    inc      = issue && sb.ID_long;
    set      = (inc && sb.ID_RegWrite && sb.ID_rd != 5'd0) ? 32'd1 << sb.ID_rd : 32'd0;
  end
  // Clear is applied before set, so a same-cycle reissue to the completing rd keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      hang        <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      pending     <= pend_eff | set;
      outstanding <= outstanding + {3'd0, inc} - {3'd0, dec};
      err         <= err | (sb.WB_long_done && outstanding == 4'd0);
      stall_cnt   <= stall ? stall_cnt + 8'd1 : 8'd0;
      hang        <= hang | (stall && stall_cnt == 8'(TIMEOUT - 1));
    end
  end
  assign sb.Stall        = stall;
  assign sb.ID_EX_Bubble = stall;
  assign sb.Pending      = pending;
  assign sb.Outstanding  = outstanding;
  assign sb.Err          = err;
  assign sb.Hang         = hang;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed test-plan steps plus randomized traffic against a behavioural model
module tb_hazard_scoreboard;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit [31:0] m_pend;
  int m_cnt, m_run;
  bit m_err, m_hang;
  logic last_stall;
  hazard_scoreboard_if sb();
  hazard_scoreboard #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2, input bit u2,
                       input bit [4:0] d, input bit rw, input bit lg, input bit fl, input bit dn,
                       input bit [4:0] wr);
    sb.ID_valid = v; sb.ID_rs1 = r1; sb.ID_rs1_used = u1; sb.ID_rs2 = r2; sb.ID_rs2_used = u2;
    sb.ID_rd = d; sb.ID_RegWrite = rw; sb.ID_long = lg; sb.Flush = fl;
    sb.WB_long_done = dn; sb.WB_rd = wr;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic bit busy(input bit [31:0] pe, input bit [4:0] r);
    return r != 0 && pe[r];
  endfunction
  // One cycle: compare everything against the model, advance the model, move to next negedge.
  task automatic step();
    bit [31:0] pe;
    int ce;
    bit st, iss;
    #1;
    pe = m_pend;
    if (sb.WB_long_done && sb.WB_rd != 0) pe[sb.WB_rd] = 1'b0;
    ce = (sb.WB_long_done && m_cnt > 0) ? m_cnt - 1 : m_cnt;
    st = sb.ID_valid && !sb.Flush &&
         ((sb.ID_rs1_used && busy(pe, sb.ID_rs1)) || (sb.ID_rs2_used && busy(pe, sb.ID_rs2)) ||
          (sb.ID_RegWrite && busy(pe, sb.ID_rd)) || (sb.ID_long && ce == MAX_OUT));
    iss = sb.ID_valid && !st && !sb.Flush;
    last_stall = sb.Stall;
    chk("stall", sb.Stall, st);
    chk("bubble", sb.ID_EX_Bubble, st);
    chk("pending", sb.Pending, m_pend);
    chk("outstanding", sb.Outstanding, m_cnt);
    chk("err", sb.Err, m_err);
    chk("hang", sb.Hang, m_hang);
    if (sb.WB_long_done) begin
      if (m_cnt > 0) m_cnt--; else m_err = 1;
    end
    m_pend = pe;
    if (iss && sb.ID_long) begin
      m_cnt++;
      if (sb.ID_RegWrite && sb.ID_rd != 0) m_pend[sb.ID_rd] = 1'b1;
    end
    m_run = st ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_hang = 1;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic model_reset();
    m_pend = 0; m_cnt = 0; m_run = 0; m_err = 0; m_hang = 0;
  endtask
  initial begin
    bit [4:0] w;
    bit dn, found;
    int k;
    model_reset();
    idle();
    #2;
    chk("rst_pending", sb.Pending, 0);
    chk("rst_outstanding", sb.Outstanding, 0);
    chk("rst_err_hang", {sb.Err, sb.Hang}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // RAW on a pending load, released by same-cycle writeback
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
    chk("t1_pend", sb.Pending, 32'h20);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t1_raw_stall", last_stall, 1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5); step();
    chk("t1_bypass", last_stall, 0);
    chk("t1_cleared", sb.Pending, 0);
    // capacity limit
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 1, 1, 0, 0, 0); step();
    end
    chk("t2_full", sb.Outstanding, 4);
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0); step();
    chk("t2_cap_stall", last_stall, 1);
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 1); step();
    chk("t2_cap_bypass", last_stall, 0);
    chk("t2_still_full", sb.Outstanding, 4);
    for (int i = 2; i <= 6; i++) if (i != 5) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i)); step();
    end
    chk("t2_drained", sb.Outstanding, 0);
    // WAW and flush
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); step();
    chk("t3_waw_stall", last_stall, 1);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0); step();
    chk("t3_flush", last_stall, 0);
    chk("t3_pend", sb.Pending, 32'h80);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step();
    // same-cycle set and clear
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9); step();
    chk("t4_set_wins", sb.Pending[9], 1);
    chk("t4_cnt", sb.Outstanding, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step();
    // spurious completion
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3); step();
    chk("t5_err", sb.Err, 1);
    chk("t5_cnt", sb.Outstanding, 0);
    // watchdog and x0
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step();
    chk("t6_x0", last_stall, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("t6_no_hang_yet", sb.Hang, 0);
    step();
    chk("t6_hang", sb.Hang, 1);
    chk("t6_err_kept", sb.Err, 1);
    // asynchronous reset in mid-cycle
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_pend", sb.Pending, 0);
    chk("t7_rst_cnt", sb.Outstanding, 0);
    chk("t7_rst_flags", {sb.Err, sb.Hang, sb.Stall}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      dn = (m_cnt > 0 && $urandom_range(2) == 0) || $urandom_range(199) == 0;
      w = 0;
      found = 0;
      k = $urandom_range(31);
      for (int j = 0; j < 32; j++)
        if (!found && m_pend[(k + j) % 32]) begin
          w = 5'((k + j) % 32);
          found = 1;
        end
      drive($urandom_range(3) != 0, 5'($urandom_range(7)), $urandom_range(1) == 1,
            5'($urandom_range(7)), $urandom_range(1) == 1, 5'($urandom_range(7)),
            $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(9) == 0, dn,
            dn ? w : 5'($urandom_range(31)));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
